// File: rtl/pll_dyn_pkg.sv
// Shared types and the compile-time divider preset table for pll_dyn_ctrl.
// Selects use the inverted encoding: 64-N for 6-bit fields, 128-N for 7-bit fields.
package pll_dyn_pkg;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [6:0] mdsel;
    logic [6:0] odsel0;
    logic [6:0] odsel1;
  } preset_t;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    WAIT_LOCK  = 3'd1,
    SETTLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } state_t;

  localparam int MAX_PRESETS = 8;

  // fvco = 50 MHz * FBDIV * MDIV / IDIV, fout0 = fvco / ODIV0, fout1 = fvco / ODIV1.
  function automatic preset_t mk_preset(input int idiv, input int fbdiv, input int mdiv,
                                        input int odiv0, input int odiv1);
    preset_t p;
    p.idsel  = 6'(64 - idiv);
    p.fbdsel = 6'(64 - fbdiv);
    p.mdsel  = 7'(128 - mdiv);
    p.odsel0 = 7'(128 - odiv0);
    p.odsel1 = 7'(128 - odiv1);
    return p;
  endfunction

  // 0: 126 MHz, 1: 100 MHz, 2: 74.25 MHz (+371.25 MHz), 3: 25.2 MHz (+126 MHz); 4..7 spare.
  localparam preset_t PLL_PRESETS [MAX_PRESETS] = '{
    mk_preset(5,  1, 63,  5,  10),
    mk_preset(1,  1, 16,  8,  16),
    mk_preset(20, 3, 99,  10, 2),
    mk_preset(25, 3, 126, 30, 6),
    mk_preset(1,  1, 16,  8,  16),
    mk_preset(1,  1, 16,  8,  16),
    mk_preset(1,  1, 16,  8,  16),
    mk_preset(1,  1, 16,  8,  16)
  };

endpackage

// File: rtl/pll_dyn_ctrl_lock_sync.sv
// lock_sync: two-flop synchronizer for the asynchronous PLL LOCK, cleared to 0 on reset.
module lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl: runtime preset switching for the GW5A PLL (reset, lock, settle, retry).
// Define PLL_DYN_CTRL_AUTO_RELOCK_EN to relock on the same preset after lock loss in RUN.
module pll_dyn_ctrl
  import pll_dyn_pkg::*;
#(
  parameter int NUM_PRESETS   = 4,
  parameter int DEFAULT_SEL   = 0,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel,
  input  logic       sel_valid,
  output logic       sel_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [6:0] mdsel,
  output logic [6:0] odsel0,
  output logic [6:0] odsel1,
  output logic [2:0] cur_sel,
  output logic       ready,
  output logic       busy,
  output logic       fail,
  output logic       sel_err,
  output state_t     state_dbg
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);
  localparam logic [3:0]       NUM_P    = 4'(NUM_PRESETS);
  localparam logic [2:0]       DEF_SEL  = 3'(DEFAULT_SEL);

  state_t           state, state_d;
  logic [RST_W-1:0] rst_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [ST_W-1:0]  settle_cnt;
  logic [RT_W-1:0]  retry_cnt, retry_d, retry_inc;
  preset_t          div_q;
  logic             lock_s;
  logic             xfer, sel_bad, load, err;

  lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Handshake: sel transfers on sel_valid && sel_ready; sel_ready is high only in RUN
  // and FAIL, and a sel_valid seen while busy is dropped, never queued.
  assign xfer      = sel_valid && sel_ready;
  assign sel_bad   = {1'b0, sel} >= NUM_P;
  assign retry_inc = retry_cnt + 1'b1;

  always_comb begin
    state_d = state;
    retry_d = retry_cnt;
    load    = 1'b0;
    err     = xfer && sel_bad;
    case (state)
      RST_ASSERT: begin
        if (rst_cnt == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = SETTLE;
        end else if (to_cnt == TO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RT_MAX) ? FAIL : RST_ASSERT;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (settle_cnt == ST_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (xfer && !sel_bad) begin
          load    = 1'b1;
          retry_d = '0;
          state_d = RST_ASSERT;
        end else if (!lock_s) begin
`ifdef PLL_DYN_CTRL_AUTO_RELOCK_EN
          retry_d = '0;
          state_d = RST_ASSERT;
`else
          state_d = FAIL;
`endif
        end
      end
      FAIL: begin
        if (xfer && !sel_bad) begin
          load    = 1'b1;
          retry_d = '0;
          state_d = RST_ASSERT;
        end
      end
      default: state_d = RST_ASSERT;
    endcase
  end

  // Counters run only while the state is held and restart on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_ASSERT;
      rst_cnt    <= '0;
      to_cnt     <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
    end else begin
      state      <= state_d;
      retry_cnt  <= retry_d;
      rst_cnt    <= (state == RST_ASSERT && state_d == RST_ASSERT) ? rst_cnt + 1'b1 : '0;
      to_cnt     <= (state == WAIT_LOCK && state_d == WAIT_LOCK) ? to_cnt + 1'b1 : '0;
      settle_cnt <= (state == SETTLE && state_d == SETTLE) ? settle_cnt + 1'b1 : '0;
    end
  end

  // Status flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset <= 1'b1;
      ready     <= 1'b0;
      busy      <= 1'b1;
      fail      <= 1'b0;
      sel_ready <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      pll_reset <= (state_d == RST_ASSERT) || (state_d == FAIL);
      ready     <= (state_d == RUN);
      busy      <= (state_d == RST_ASSERT) || (state_d == WAIT_LOCK) || (state_d == SETTLE);
      fail      <= (state_d == FAIL);
      sel_ready <= (state_d == RUN) || (state_d == FAIL);
      sel_err   <= err;
    end
  end

  // Dividers load only together with the move into RST_ASSERT, so the PLL is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_sel <= DEF_SEL;
      div_q   <= PLL_PRESETS[DEF_SEL];
    end else if (load) begin
      cur_sel <= sel;
      div_q   <= PLL_PRESETS[sel];
    end
  end

  assign idsel     = div_q.idsel;
  assign fbdsel    = div_q.fbdsel;
  assign mdsel     = div_q.mdsel;
  assign odsel0    = div_q.odsel0;
  assign odsel1    = div_q.odsel1;
  assign state_dbg = state;

endmodule
